// File: rtl/xrv_pipe_ctrl.sv
// xrv_pipe_ctrl: pipeline stall/flush controller.
//   - Jump arbitration: any jump request redirects fetch and flushes the pipe;
//     the lowest-index requester supplies the target.
//   - Per-channel multicycle tracking: a two-state FSM per channel (IDLE/BUSY)
//     held directly in mc_busy, so the FSM state is visible at the port.
//   - Stall and flush cycle counters, saturating, with synchronous clear.
// Optional feature: define XRV_PIPE_CTRL_TMO_EN to add a per-channel watchdog
// that aborts a BUSY channel after TMO_CYC cycles and pulses mc_tmo.
// Handshake: mc_start/mc_done are single-cycle pulses sampled on the rising
// edge; a start is accepted only from IDLE, a done only matters while the op
// is in flight (or in the issue cycle, which makes it a single-cycle op).
module xrv_pipe_ctrl #(
   parameter int NJMP    = 2,
   parameter int NMC     = 2,
   parameter int AW      = 32,
   parameter int CW      = 32,
   parameter int TMO_CYC = 255
) (
   input  logic               clk,
   input  logic               rstb,
   input  logic [NMC-1:0]     mc_start,
   input  logic [NMC-1:0]     mc_done,
   input  logic [NJMP-1:0]    jmp_req,
   input  logic [NJMP*AW-1:0] jmp_addr_in,
   input  logic               cnt_clr,
   output logic               stalling,
   output logic               flush,
   output logic               jmp,
   output logic [AW-1:0]      jmp_addr,
   output logic [NMC-1:0]     mc_busy,
   output logic [CW-1:0]      stall_cnt,
   output logic [CW-1:0]      flush_cnt,
   output logic [NMC-1:0]     mc_tmo
);

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_BUSY = 1'b1;

   logic [NMC-1:0] busy_nxt;
   logic [NMC-1:0] tmo_exp;

   // Any jump redirects fetch; the flush is the same event seen by the pipe.
   assign jmp   = |jmp_req;
   assign flush = jmp;

   // A channel stalls the pipe from its issue cycle until its done cycle.
   assign stalling = |((mc_start | mc_busy) & ~mc_done);

   // Priority select of the jump target: lowest index wins, zero when idle.
   always_comb begin
      jmp_addr = '0;
      for (int j = NJMP - 1; j >= 0; j--) begin
         if (jmp_req[j]) jmp_addr = jmp_addr_in[j*AW +: AW];
      end
   end

   // Next-state logic of the per-channel IDLE/BUSY FSMs.
   always_comb begin
      busy_nxt = mc_busy;
      for (int i = 0; i < NMC; i++) begin
         case (mc_busy[i])
            ST_IDLE: if (mc_start[i] & ~mc_done[i] & ~jmp) busy_nxt[i] = ST_BUSY;
            default: if (mc_done[i] | jmp | tmo_exp[i])    busy_nxt[i] = ST_IDLE;
         endcase
      end
   end

   // FSM state register; reset abandons any op in flight.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) mc_busy <= '0;
      else       mc_busy <= busy_nxt;
   end

   // Saturating performance counters; clear beats a same-cycle increment.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (cnt_clr) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stalling && (stall_cnt != {CW{1'b1}})) stall_cnt <= stall_cnt + CW'(1);
         if (flush && (flush_cnt != {CW{1'b1}}))    flush_cnt <= flush_cnt + CW'(1);
      end
   end

`ifdef XRV_PIPE_CTRL_TMO_EN
   // Counter just wide enough to hold TMO_CYC.
   localparam int TW = (TMO_CYC < 1) ? 1 : $clog2(TMO_CYC + 1);

   logic [TW-1:0] tmo_cnt [NMC];

   // Expiry: still BUSY, limit reached and no completion arriving this cycle.
   always_comb begin
      for (int i = 0; i < NMC; i++) begin
         tmo_exp[i] = mc_busy[i] & ~mc_done[i] & (tmo_cnt[i] == TW'(TMO_CYC));
      end
   end

   // Watchdog counters and the one-cycle abort pulse (suppressed by a jump).
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         for (int i = 0; i < NMC; i++) tmo_cnt[i] <= '0;
         mc_tmo <= '0;
      end else begin
         for (int i = 0; i < NMC; i++) begin
            if (!mc_busy[i] && busy_nxt[i])
               tmo_cnt[i] <= '0;
            else if (mc_busy[i] && !mc_done[i] && !tmo_exp[i])
               tmo_cnt[i] <= tmo_cnt[i] + TW'(1);
         end
         mc_tmo <= tmo_exp & ~{NMC{jmp}};
      end
   end
`else
   // No watchdog: BUSY lasts until done or jump.
   logic unused_tmo_cyc;
   assign unused_tmo_cyc = (TMO_CYC != 0);
   assign tmo_exp        = '0;
   assign mc_tmo         = '0;
`endif

endmodule

// File: tb/tb_xrv_pipe_ctrl.sv
// Directed bench for xrv_pipe_ctrl (NJMP=2, NMC=2, AW=32, CW=4, TMO_CYC=4).
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit
// later, so combinational outputs reflect the current cycle and registered
// outputs reflect the state loaded at the last edge.
module tb_xrv_pipe_ctrl;

   localparam int NJMP = 2;
   localparam int NMC  = 2;
   localparam int AW   = 32;
   localparam int CW   = 4;
   localparam int TMO  = 4;

   logic               clk  = 1'b0;
   logic               rstb = 1'b1;
   logic [NMC-1:0]     mc_start = '0;
   logic [NMC-1:0]     mc_done  = '0;
   logic [NJMP-1:0]    jmp_req  = '0;
   logic [NJMP*AW-1:0] jmp_addr_in = '0;
   logic               cnt_clr = 1'b0;
   logic               stalling, flush, jmp;
   logic [AW-1:0]      jmp_addr;
   logic [NMC-1:0]     mc_busy, mc_tmo;
   logic [CW-1:0]      stall_cnt, flush_cnt;

   int n_chk = 0;
   int n_bad = 0;

   xrv_pipe_ctrl #(.NJMP(NJMP), .NMC(NMC), .AW(AW), .CW(CW), .TMO_CYC(TMO)) dut (
      .clk(clk), .rstb(rstb), .mc_start(mc_start), .mc_done(mc_done),
      .jmp_req(jmp_req), .jmp_addr_in(jmp_addr_in), .cnt_clr(cnt_clr),
      .stalling(stalling), .flush(flush), .jmp(jmp), .jmp_addr(jmp_addr),
      .mc_busy(mc_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
      .mc_tmo(mc_tmo)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge (start of the next cycle).
   task automatic next();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after driving inputs.
   task automatic settle();
      #1;
   endtask

   initial begin
      jmp_addr_in = {32'h0000_0200, 32'h0000_0100};

      // ---------------- reset ----------------
      #2 rstb = 1'b0;
      settle();
      chk("rst_busy", mc_busy, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_flush_cnt", flush_cnt, 0);
      chk("rst_tmo", mc_tmo, 0);
      mc_start = 2'b01;
      settle();
      chk("rst_comb_stall", stalling, 1);
      mc_done = 2'b01;
      settle();
      chk("rst_comb_stall_done", stalling, 0);
      mc_start = '0; mc_done = '0; jmp_req = 2'b10;
      settle();
      chk("rst_comb_jmp", jmp, 1);
      chk("rst_comb_addr", jmp_addr, 32'h200);
      jmp_req = '0;
      next();
      next();
      chk("rst_hold_stall_cnt", stall_cnt, 0);
      chk("rst_hold_flush_cnt", flush_cnt, 0);
      rstb = 1'b1;                              // cycle 0

      // ---------------- basic multicycle op ----------------
      next(); mc_start = 2'b01; settle();     // cycle 1
      chk("op_c1_stall", stalling, 1);
      chk("op_c1_busy", mc_busy, 0);
      next(); mc_start = 2'b00; settle();     // cycle 2
      chk("op_c2_stall", stalling, 1);
      chk("op_c2_busy", mc_busy, 2'b01);
      next(); settle();                       // cycle 3
      chk("op_c3_stall", stalling, 1);
      chk("op_c3_busy", mc_busy, 2'b01);
      next(); mc_done = 2'b01; settle();      // cycle 4
      chk("op_c4_stall", stalling, 0);
      chk("op_c4_busy", mc_busy, 2'b01);
      next(); mc_done = 2'b00; settle();      // cycle 5
      chk("op_c5_busy", mc_busy, 0);
      chk("op_stall_cnt", stall_cnt, 3);

      // ---------------- jump priority ----------------
      jmp_req = 2'b11; settle();
      chk("jmp11_jmp", jmp, 1);
      chk("jmp11_flush", flush, 1);
      chk("jmp11_addr", jmp_addr, 32'h100);
      next(); jmp_req = 2'b10; settle();
      chk("jmp10_addr", jmp_addr, 32'h200);
      chk("jmp_flush_cnt1", flush_cnt, 1);
      next(); jmp_req = 2'b00; settle();
      chk("jmp00_jmp", jmp, 0);
      chk("jmp00_addr", jmp_addr, 0);
      chk("jmp_flush_cnt2", flush_cnt, 2);

      // ---------------- jump cancels same-cycle start ----------------
      mc_start = 2'b10; jmp_req = 2'b10; settle();
      chk("cancel_stall", stalling, 1);
      next(); mc_start = '0; jmp_req = '0; settle();
      chk("cancel_busy", mc_busy, 0);
      chk("cancel_stall_after", stalling, 0);
      chk("cancel_stall_cnt", stall_cnt, 4);
      chk("cancel_flush_cnt", flush_cnt, 3);

      // ---------------- single-cycle op ----------------
      mc_start = 2'b01; mc_done = 2'b01; settle();
      chk("single_stall", stalling, 0);
      next(); mc_start = '0; mc_done = '0; settle();
      chk("single_busy", mc_busy, 0);
      chk("single_stall_cnt", stall_cnt, 4);

      // ---------------- jump aborts BUSY, start while busy ignored ----------------
      mc_start = 2'b01; settle();
      next(); mc_start = 2'b00; settle();
      chk("abort_busy_pre", mc_busy, 2'b01);
      jmp_req = 2'b01; mc_start = 2'b01; settle();
      chk("abort_stall", stalling, 1);
      next(); jmp_req = '0; mc_start = '0; settle();
      chk("abort_busy_post", mc_busy, 0);
      chk("abort_stall_cnt", stall_cnt, 6);
      chk("abort_flush_cnt", flush_cnt, 4);

      // ---------------- counter clear ----------------
      cnt_clr = 1'b1;
      next(); cnt_clr = 1'b0; settle();
      chk("clr_stall_cnt", stall_cnt, 0);
      chk("clr_flush_cnt", flush_cnt, 0);

      // ---------------- watchdog ----------------
      mc_start = 2'b01; settle();             // issue cycle S
      next(); mc_start = '0; settle();
`ifdef XRV_PIPE_CTRL_TMO_EN
      for (int k = 1; k <= TMO + 1; k++) begin
         chk($sformatf("tmo_busy_c%0d", k), mc_busy, 2'b01);
         chk($sformatf("tmo_idle_c%0d", k), mc_tmo, 0);
         next(); settle();
      end
      chk("tmo_busy_fall", mc_busy, 0);
      chk("tmo_pulse", mc_tmo, 2'b01);
      chk("tmo_stall_off", stalling, 0);
      next(); settle();
      chk("tmo_pulse_end", mc_tmo, 0);
      chk("tmo_stall_cnt", stall_cnt, 6);
`else
      for (int k = 0; k < 100; k++) next();
      settle();
      chk("notmo_busy_100", mc_busy, 2'b01);
      chk("notmo_tmo", mc_tmo, 0);
      mc_done = 2'b01;
      next(); mc_done = '0; settle();
      chk("notmo_busy_done", mc_busy, 0);
`endif

      // ---------------- saturation and clear under stall ----------------
      cnt_clr = 1'b1;
      next(); cnt_clr = 1'b0; settle();
      chk("sat_pre_clr", stall_cnt, 0);
      mc_start = 2'b01; settle();
      for (int k = 1; k <= 20; k++) begin
         next(); settle();
         if (k == 10) chk("sat_mid", stall_cnt, 10);
      end
      chk("sat_stall_cnt", stall_cnt, 15);
      chk("sat_flush_cnt", flush_cnt, 0);
      cnt_clr = 1'b1;
      next(); cnt_clr = 1'b0; settle();
      chk("sat_clr_stall_cnt", stall_cnt, 0);
      next(); settle();
      chk("sat_recount", stall_cnt, 1);
      mc_start = '0; mc_done = 2'b11;
      next(); mc_done = '0; settle();
      chk("sat_end_busy", mc_busy, 0);

      // ---------------- reset mid-op ----------------
      mc_start = 2'b10; settle();
      next(); mc_start = '0; settle();
      chk("midrst_busy_pre", mc_busy, 2'b10);
      rstb = 1'b0; settle();
      chk("midrst_busy_async", mc_busy, 0);
      chk("midrst_stall_cnt", stall_cnt, 0);
      next();
      rstb = 1'b1;
      next(); settle();
      chk("midrst_busy_post", mc_busy, 0);
      chk("midrst_stall_post", stalling, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
